mult_div_unit: RTL and testbench

- Iterative multiply/divide unit sitting directly downstream of the register file in the execute stage.
- Consumes the two register read ports (`readData1` → `operandA`, `readData2` → `operandB`) and produces the architectural HI/LO pair for MULT/MULTU/DIV/DIVU.
- Also accepts MTHI/MTLO writes so that MFHI/MFLO logic can read `hi`/`lo` directly.
- Multi-cycle with a start/busy/done handshake; the pipeline controller stalls on `busy`.

---
 rtl/mult_div_unit_if.sv | 28 ++
 rtl/mult_div_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the execute-stage controller and mult_div_unit.
// The controller side is the master; the iterative unit is the slave.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic             hiWriteEnable;
    logic             loWriteEnable;
    logic [WIDTH-1:0] moveData;
    logic             busy;
    logic             done;
    logic             divByZero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operandA, operandB, hiWriteEnable, loWriteEnable, moveData,
        input  busy, done, divByZero, hi, lo
    );

    modport slave (
        input  start, op, operandA, operandB, hiWriteEnable, loWriteEnable, moveData,
        output busy, done, divByZero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO pair.
// Shift-add multiply and restoring divide on magnitudes, sign fix-up in FINISH.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   LAST_COUNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [WIDTH-1:0]   ZERO       = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES       = {WIDTH{1'b1}};
    localparam logic [WIDTH:0]     ZERO_EXT   = {(WIDTH+1){1'b0}};
    localparam logic [2*WIDTH-1:0] ZERO_WIDE  = {(2*WIDTH){1'b0}};

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CALC   = 2'b01,
        FINISH = 2'b10
    } state_t;

    state_t               state_r;
    state_t               nextState_s;
    logic [CNT_W-1:0]     count_r;
    logic                 isDiv_r;
    logic                 divZero_r;
    logic                 negMain_r;
    logic                 negRem_r;
    logic [WIDTH-1:0]     operand_r;
    logic [WIDTH-1:0]     rawA_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 divByZero_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;

    logic                 signedOp_s;
    logic                 signA_s;
    logic                 signB_s;
    logic [WIDTH-1:0]     absA_s;
    logic [WIDTH-1:0]     absB_s;
    logic [WIDTH:0]       mulSum_s;
    logic [WIDTH:0]       divTrial_s;
    logic [WIDTH:0]       divDiff_s;
    logic [2*WIDTH-1:0]   accStep_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quot_s;
    logic [WIDTH-1:0]     rem_s;
    logic [WIDTH-1:0]     resHi_s;
    logic [WIDTH-1:0]     resLo_s;

    // Operand magnitudes and signs; op[0]==0 selects the signed variants.
    always_comb begin
        signedOp_s = ~bus.op[0];
        signA_s    = signedOp_s & bus.operandA[WIDTH-1];
        signB_s    = signedOp_s & bus.operandB[WIDTH-1];
        if (signA_s) begin
            absA_s = ZERO - bus.operandA;
        end else begin
            absA_s = bus.operandA;
        end
        if (signB_s) begin
            absB_s = ZERO - bus.operandB;
        end else begin
            absB_s = bus.operandB;
        end
    end

    // One iteration: acc = {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mulSum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                   + (acc_r[0] ? {1'b0, operand_r} : ZERO_EXT);
        divTrial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        divDiff_s  = divTrial_s - {1'b0, operand_r};
        if (isDiv_r) begin
            // A borrow out of the trial subtraction means restore and shift in 0.
            if (divDiff_s[WIDTH]) begin
                accStep_s = {divTrial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end else begin
                accStep_s = {divDiff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end
        end else begin
            accStep_s = {mulSum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Sign correction and divide-by-zero override applied on the FINISH cycle.
    always_comb begin
        prod_s = negMain_r ? (ZERO_WIDE - acc_r) : acc_r;
        quot_s = acc_r[WIDTH-1:0];
        rem_s  = acc_r[2*WIDTH-1:WIDTH];
        if (isDiv_r) begin
            if (divZero_r) begin
                resHi_s = rawA_r;
                resLo_s = ONES;
            end else begin
                resHi_s = negRem_r  ? (ZERO - rem_s)  : rem_s;
                resLo_s = negMain_r ? (ZERO - quot_s) : quot_s;
            end
        end else begin
            resHi_s = prod_s[2*WIDTH-1:WIDTH];
            resLo_s = prod_s[WIDTH-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // FSM next-state logic; start is only honoured from IDLE.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    nextState_s = CALC;
                end else begin
                    nextState_s = IDLE;
                end
            end
            CALC: begin
                if (count_r == LAST_COUNT) begin
                    nextState_s = FINISH;
                end else begin
                    nextState_s = CALC;
                end
            end
            FINISH:  nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // Operand capture on acceptance and accumulator/counter stepping while calculating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r   <= CNT_ZERO;
            isDiv_r   <= 1'b0;
            divZero_r <= 1'b0;
            negMain_r <= 1'b0;
            negRem_r  <= 1'b0;
            operand_r <= ZERO;
            rawA_r    <= ZERO;
            acc_r     <= ZERO_WIDE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        count_r   <= CNT_ZERO;
                        isDiv_r   <= bus.op[1];
                        divZero_r <= bus.op[1] & (bus.operandB == ZERO);
                        negMain_r <= signA_s ^ signB_s;
                        negRem_r  <= signA_s;
                        rawA_r    <= bus.operandA;
                        if (bus.op[1]) begin
                            operand_r <= absB_s;
                            acc_r     <= {ZERO, absA_s};
                        end else begin
                            operand_r <= absA_s;
                            acc_r     <= {ZERO, absB_s};
                        end
                    end
                end
                CALC: begin
                    acc_r   <= accStep_s;
                    count_r <= count_r + CNT_ONE;
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    // Handshake outputs: busy follows the next state, done/divByZero pulse on FINISH exit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            divByZero_r <= 1'b0;
        end else begin
            busy_r      <= (nextState_s != IDLE);
            done_r      <= (state_r == FINISH);
            divByZero_r <= (state_r == FINISH) & divZero_r;
        end
    end

    // HI/LO: result write on FINISH, MTHI/MTLO only while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r <= ZERO;
            lo_r <= ZERO;
        end else if (state_r == FINISH) begin
            hi_r <= resHi_s;
            lo_r <= resLo_s;
        end else if (state_r == IDLE) begin
            if (bus.hiWriteEnable) begin
                hi_r <= bus.moveData;
            end
            if (bus.loWriteEnable) begin
                lo_r <= bus.moveData;
            end
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.divByZero = divByZero_r;
    assign bus.hi        = hi_r;
    assign bus.lo        = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: handshake timing, arithmetic
// corner cases, divide-by-zero, ignored starts, MTHI/MTLO gating and reset abort.
module tb_mult_div_unit;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic clk;
    logic reset;
    int   assertions;
    int   failures;
    int   doneCount;

    mult_div_unit_if #(.WIDTH(32)) mdIf ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mdIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertions++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a request for one edge, then scrambles the operands.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        mdIf.start    = 1'b1;
        mdIf.op       = o;
        mdIf.operandA = a;
        mdIf.operandB = b;
        @(negedge clk);
        mdIf.start    = 1'b0;
        mdIf.op       = ~o;
        mdIf.operandA = ~a;
        mdIf.operandB = b + 32'd1;
    endtask

    task automatic waitDone(input string tag, input int expLat);
        int lat;
        lat = 0;
        while (mdIf.done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(expLat));
    endtask

    task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expHi,
                         input logic [31:0] expLo, input logic expDz);
        launch(o, a, b);
        check({tag, " busy"}, 64'(mdIf.busy), 64'(1'b1));
        waitDone(tag, 33);
        check({tag, " hi"}, 64'(mdIf.hi), 64'(expHi));
        check({tag, " lo"}, 64'(mdIf.lo), 64'(expLo));
        check({tag, " busy at done"}, 64'(mdIf.busy), 64'(1'b0));
        check({tag, " divByZero"}, 64'(mdIf.divByZero), 64'(expDz));
        @(negedge clk);
        check({tag, " done cleared"}, 64'(mdIf.done), 64'(1'b0));
        check({tag, " divByZero cleared"}, 64'(mdIf.divByZero), 64'(1'b0));
        check({tag, " lo held"}, 64'(mdIf.lo), 64'(expLo));
    endtask

    initial begin
        assertions         = 0;
        failures           = 0;
        reset              = 1'b1;
        mdIf.start         = 1'b0;
        mdIf.op            = 2'b00;
        mdIf.operandA      = 32'd0;
        mdIf.operandB      = 32'd0;
        mdIf.hiWriteEnable = 1'b0;
        mdIf.loWriteEnable = 1'b0;
        mdIf.moveData      = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset hi", 64'(mdIf.hi), 64'(32'd0));
        check("reset lo", 64'(mdIf.lo), 64'(32'd0));
        check("reset busy", 64'(mdIf.busy), 64'(1'b0));
        check("reset done", 64'(mdIf.done), 64'(1'b0));
        reset = 1'b0;
        @(negedge clk);
        check("idle busy", 64'(mdIf.busy), 64'(1'b0));

        // MTHI / MTLO while idle
        mdIf.hiWriteEnable = 1'b1;
        mdIf.moveData      = 32'h0000_AAAA;
        @(negedge clk);
        mdIf.hiWriteEnable = 1'b0;
        check("mthi hi", 64'(mdIf.hi), 64'(32'h0000_AAAA));
        check("mthi lo untouched", 64'(mdIf.lo), 64'(32'd0));
        mdIf.loWriteEnable = 1'b1;
        mdIf.moveData      = 32'h0000_5555;
        @(negedge clk);
        mdIf.loWriteEnable = 1'b0;
        check("mtlo lo", 64'(mdIf.lo), 64'(32'h0000_5555));
        check("mtlo hi untouched", 64'(mdIf.hi), 64'(32'h0000_AAAA));

        // Reset mid-operation aborts
        launch(OP_MULTU, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort busy", 64'(mdIf.busy), 64'(1'b0));
        check("abort hi", 64'(mdIf.hi), 64'(32'd0));
        check("abort lo", 64'(mdIf.lo), 64'(32'd0));
        @(negedge clk);
        reset = 1'b0;
        doneCount = 0;
        repeat (40) begin
            @(negedge clk);
            if (mdIf.done === 1'b1) doneCount++;
        end
        check("abort no done", 64'(doneCount), 64'(0));
        check("abort lo stays", 64'(mdIf.lo), 64'(32'd0));

        // Multiplies
        runOp("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        runOp("mult -3*7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        runOp("mult minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);

        // Divides
        runOp("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

        // DIVU 100/7 with an MTLO attempt while busy
        launch(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        mdIf.loWriteEnable = 1'b1;
        mdIf.hiWriteEnable = 1'b1;
        mdIf.moveData      = 32'h0000_5555;
        @(negedge clk);
        mdIf.loWriteEnable = 1'b0;
        mdIf.hiWriteEnable = 1'b0;
        check("mtlo busy lo", 64'(mdIf.lo), 64'(32'hFFFF_FFFD));
        check("mthi busy hi", 64'(mdIf.hi), 64'(32'hFFFF_FFFF));
        waitDone("divu 100/7", 23);
        check("divu 100/7 lo", 64'(mdIf.lo), 64'(32'd14));
        check("divu 100/7 hi", 64'(mdIf.hi), 64'(32'd2));

        runOp("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        runOp("divu by0", OP_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        runOp("div by0 neg", OP_DIV, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1);

        // Start coinciding with MTHI: write lands now, result overwrites at FINISH
        mdIf.hiWriteEnable = 1'b1;
        mdIf.moveData      = 32'h0000_BEEF;
        launch(OP_MULTU, 32'd2, 32'd3);
        mdIf.hiWriteEnable = 1'b0;
        check("start+mthi hi", 64'(mdIf.hi), 64'(32'h0000_BEEF));
        waitDone("start+mthi", 33);
        check("start+mthi result hi", 64'(mdIf.hi), 64'(32'd0));
        check("start+mthi result lo", 64'(mdIf.lo), 64'(32'd6));

        // Starts while busy and on the FINISH edge are ignored
        @(negedge clk);
        launch(OP_MULTU, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        mdIf.start    = 1'b1;
        mdIf.op       = OP_MULT;
        mdIf.operandA = 32'd100;
        mdIf.operandB = 32'd100;
        @(negedge clk);
        mdIf.start = 1'b0;
        check("busy start busy", 64'(mdIf.busy), 64'(1'b1));
        repeat (27) @(negedge clk);
        check("pre-finish done", 64'(mdIf.done), 64'(1'b0));
        check("pre-finish busy", 64'(mdIf.busy), 64'(1'b1));
        mdIf.start    = 1'b1;
        mdIf.op       = OP_MULTU;
        mdIf.operandA = 32'd7;
        mdIf.operandB = 32'd7;
        @(negedge clk);
        mdIf.start = 1'b0;
        check("ignored starts done", 64'(mdIf.done), 64'(1'b1));
        check("ignored starts hi", 64'(mdIf.hi), 64'(32'd0));
        check("ignored starts lo", 64'(mdIf.lo), 64'(32'd12));
        check("ignored starts busy", 64'(mdIf.busy), 64'(1'b0));
        doneCount = 0;
        repeat (40) begin
            @(negedge clk);
            if (mdIf.done === 1'b1) doneCount++;
        end
        check("single done pulse", 64'(doneCount), 64'(0));
        check("no relaunch busy", 64'(mdIf.busy), 64'(1'b0));
        check("no relaunch lo", 64'(mdIf.lo), 64'(32'd12));

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
